// File: rtl/zap_wb_splitter_if.sv
// Wishbone bus bundle used on both sides of zap_wb_splitter.
// dat carries write data from the initiator, rdat carries read data back.
interface zap_wb_if;
    logic        cyc;
    logic        stb;
    logic        wen;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [31:0] rdat;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, wen, sel, dat, adr, cti,
        input  rdat, ack, err
    );

    modport slave (
        input  cyc, stb, wen, sel, dat, adr, cti,
        output rdat, ack, err
    );
endinterface

// File: rtl/zap_wb_splitter.sv
// One Wishbone initiator fanned out to two responders by address decode.
// Define ZAP_WB_SPLIT_TIMEOUT_EN to terminate silent responders with an error.
module zap_wb_splitter #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'h8000_0000,
    parameter logic [31:0] S1_BASE = 32'h8000_0000,
    parameter logic [31:0] S1_MASK = 32'hF000_0000,
    parameter int          TIMEOUT = 255
) (
    input  logic     i_clk,
    input  logic     i_reset,
    zap_wb_if.slave  wb,
    zap_wb_if.master s0,
    zap_wb_if.master s1
);

    typedef enum logic [1:0] {IDLE, S0, S1, ERR} state_t;

    state_t      state;
    state_t      nxt;
    logic        hit0;
    logic        hit1;
    logic        eob;
    logic        rsp_ack;
    logic        tmo;
    logic        ack;
    logic        err;
    logic [31:0] rdat;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("zap_wb_splitter: TIMEOUT out of range");
    end

    assign hit0 = (wb.adr & S0_MASK) == S0_BASE;
    assign hit1 = (wb.adr & S1_MASK) == S1_BASE;
    assign eob  = wb.cti == 3'b111;

    assign rsp_ack = ((state == S0) && (s0.ack || s0.err)) ||
                     ((state == S1) && (s1.ack || s1.err));

`ifdef ZAP_WB_SPLIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic          busy;

    assign busy = (state == S0) || (state == S1);
    assign tmo  = busy && wb.stb && !rsp_ack &&
                  (cnt == CW'(TIMEOUT));

    // Holding at zero in IDLE doubles as the clear on entry to S0/S1.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (state == IDLE || ack) begin
            cnt <= '0;
        end else if (busy && wb.stb && !rsp_ack) begin
            cnt <= cnt + CW'(1);
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        s0.cyc = 1'b0;
        s0.stb = 1'b0;
        s0.wen = 1'b0;
        s0.sel = 4'h0;
        s0.dat = 32'h0;
        s0.adr = 32'h0;
        s0.cti = 3'b111;
        s1.cyc = 1'b0;
        s1.stb = 1'b0;
        s1.wen = 1'b0;
        s1.sel = 4'h0;
        s1.dat = 32'h0;
        s1.adr = 32'h0;
        s1.cti = 3'b111;
        ack    = 1'b0;
        err    = 1'b0;
        rdat   = 32'h0;
        unique case (state)
            S0: begin
                s0.cyc = wb.cyc && !tmo;
                s0.stb = wb.stb && !tmo;
                s0.wen = wb.wen;
                s0.sel = wb.sel;
                s0.dat = wb.dat;
                s0.adr = wb.adr;
                s0.cti = wb.cti;
                ack    = s0.ack || s0.err || tmo;
                err    = s0.err || tmo;
                rdat   = s0.rdat;
            end
            S1: begin
                s1.cyc = wb.cyc && !tmo;
                s1.stb = wb.stb && !tmo;
                s1.wen = wb.wen;
                s1.sel = wb.sel;
                s1.dat = wb.dat;
                s1.adr = wb.adr;
                s1.cti = wb.cti;
                ack    = s1.ack || s1.err || tmo;
                err    = s1.err || tmo;
                rdat   = s1.rdat;
            end
            ERR: begin
                ack = wb.stb;
                err = wb.stb;
            end
            default: ;
        endcase
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (wb.cyc && wb.stb) begin
                    if (hit0) begin
                        nxt = S0;
                    end else if (hit1) begin
                        nxt = S1;
                    end else begin
                        nxt = ERR;
                    end
                end
            end
            default: begin
                if (!wb.cyc || (ack && eob)) begin
                    nxt = IDLE;
                end else if (tmo) begin
                    nxt = ERR;
                end
            end
        endcase
    end

    assign wb.ack  = ack;
    assign wb.err  = err;
    assign wb.rdat = rdat;

endmodule

// File: tb/tb_zap_wb_splitter.sv
// Self-checking bench for zap_wb_splitter: vector table, corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_zap_wb_splitter;

`ifdef ZAP_WB_SPLIT_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    localparam logic [31:0] DB  = 32'hDEAD_BEEF;
    localparam logic [31:0] S1D = 32'h1234_5678;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zap_wb_if wb ();
    zap_wb_if s0 ();
    zap_wb_if s1 ();

    zap_wb_splitter #(.TIMEOUT(TO)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .wb     (wb),
        .s0     (s0),
        .s1     (s1)
    );

    int pass_n  = 0;
    int total_n = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic c, logic s, logic [2:0] t, logic [31:0] a);
        wb.cyc = c;
        wb.stb = s;
        wb.cti = t;
        wb.adr = a;
        wb.wen = 1'b0;
        wb.sel = 4'hF;
        wb.dat = 32'h0;
    endtask

    task automatic resp(logic a0, logic e0, logic a1, logic e1);
        s0.ack = a0;
        s0.err = e0;
        s1.ack = a1;
        s1.err = e1;
    endtask

    task automatic check_idle_bus(string nm);
        check({nm, ".s0cyc"}, 32'(s0.cyc), 0);
        check({nm, ".s0stb"}, 32'(s0.stb), 0);
        check({nm, ".s0cti"}, 32'(s0.cti), 7);
        check({nm, ".s0adr"}, s0.adr, 0);
        check({nm, ".s0sel"}, 32'(s0.sel), 0);
        check({nm, ".s1cyc"}, 32'(s1.cyc), 0);
        check({nm, ".s1stb"}, 32'(s1.stb), 0);
        check({nm, ".s1cti"}, 32'(s1.cti), 7);
        check({nm, ".s1adr"}, s1.adr, 0);
        check({nm, ".ack"}, 32'(wb.ack), 0);
        check({nm, ".err"}, 32'(wb.err), 0);
        check({nm, ".dat"}, wb.rdat, 0);
    endtask

    typedef struct {
        logic        cyc;
        logic        stb;
        logic [2:0]  cti;
        logic [31:0] adr;
        logic        a0;
        logic        e0;
        logic        a1;
        logic        eack;
        logic        eerr;
        logic [31:0] edat;
        logic        es0;
        logic        es1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic c, logic s, logic [2:0] t,
                               logic [31:0] a, logic a0, logic e0,
                               logic a1, logic ea, logic ee,
                               logic [31:0] ed, logic x0, logic x1);
        vec_t r;
        r.cyc = c;  r.stb = s;  r.cti = t;  r.adr = a;
        r.a0 = a0;  r.e0 = e0;  r.a1 = a1;
        r.eack = ea; r.eerr = ee; r.edat = ed;
        r.es0 = x0; r.es1 = x1;
        return r;
    endfunction

    // Reference model: which target the cycle is bound to (-1 none, 2 error).
    int          m_sel  = -1;
    int          m_wait = 0;
    logic        e_ack;
    logic        e_err;
    logic        e_to;
    logic        e_rsp;
    logic [31:0] e_dat;

    function automatic int decode(logic [31:0] a);
        logic [3:0] top;
        top = a[31:28];
        if (a < 32'h8000_0000) return 0;
        if (top == 4'h8) return 1;
        return 2;
    endfunction

    task automatic predict();
        e_rsp = (m_sel == 0) ? (s0.ack | s0.err) :
                (m_sel == 1) ? (s1.ack | s1.err) : 1'b0;
`ifdef ZAP_WB_SPLIT_TIMEOUT_EN
        e_to = (m_sel == 0 || m_sel == 1) && wb.stb && !e_rsp &&
               (m_wait == TO);
`else
        e_to = 1'b0;
`endif
        e_ack = 1'b0;
        e_err = 1'b0;
        e_dat = 32'h0;
        if (m_sel == 0) begin
            e_ack = e_rsp | e_to;
            e_err = s0.err | e_to;
            e_dat = s0.rdat;
        end else if (m_sel == 1) begin
            e_ack = e_rsp | e_to;
            e_err = s1.err | e_to;
            e_dat = s1.rdat;
        end else if (m_sel == 2) begin
            e_ack = wb.stb;
            e_err = wb.stb;
        end
    endtask

    task automatic model_step();
        predict();
        if (rst) begin
            m_sel  = -1;
            m_wait = 0;
        end else if (m_sel == -1) begin
            m_wait = 0;
            if (wb.cyc && wb.stb) m_sel = decode(wb.adr);
        end else begin
            if (e_ack) m_wait = 0;
            else if (m_sel != 2 && wb.stb && !e_rsp) m_wait++;
            if (!wb.cyc || (e_ack && wb.cti == 3'b111)) m_sel = -1;
            else if (e_to) m_sel = 2;
        end
    endtask

    task automatic cmp_rsp(string nm, int n, logic c, logic s, logic w,
                           logic [3:0] sl, logic [31:0] d,
                           logic [31:0] a, logic [2:0] t);
        logic act;
        act = (m_sel == n);
        check({nm, ".cyc"}, 32'(c), act ? 32'(wb.cyc & !e_to) : 0);
        check({nm, ".stb"}, 32'(s), act ? 32'(wb.stb & !e_to) : 0);
        check({nm, ".wen"}, 32'(w), act ? 32'(wb.wen) : 0);
        check({nm, ".sel"}, 32'(sl), act ? 32'(wb.sel) : 0);
        check({nm, ".dat"}, d, act ? wb.dat : 0);
        check({nm, ".adr"}, a, act ? wb.adr : 0);
        check({nm, ".cti"}, 32'(t), act ? 32'(wb.cti) : 7);
    endtask

    function automatic logic [31:0] rnd_adr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r[31] = 1'b0;
            1: r[31:28] = 4'h8;
            2: r[31:28] = 4'h9;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        drive(0, 0, 3'b111, 0);
        resp(0, 0, 0, 0);
        s0.rdat = DB;
        s1.rdat = S1D;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check_idle_bus("reset");
        tick();
        rst = 1'b0;

        tbl.push_back(v(1, 1, 7, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 7, 32'h10, 0, 0, 0, 0, 0, DB, 1, 0));
        tbl.push_back(v(1, 1, 7, 32'h10, 0, 0, 0, 0, 0, DB, 1, 0));
        tbl.push_back(v(1, 1, 7, 32'h10, 1, 0, 0, 1, 0, DB, 1, 0));
        tbl.push_back(v(0, 0, 7, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 2, 32'h8000_0000, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 2, 32'h8000_0000, 0, 0, 1, 1, 0, S1D, 0, 1));
        tbl.push_back(v(1, 1, 2, 32'h8000_0004, 0, 0, 1, 1, 0, S1D, 0, 1));
        tbl.push_back(v(1, 1, 2, 32'h8000_0008, 0, 0, 1, 1, 0, S1D, 0, 1));
        tbl.push_back(v(1, 1, 7, 32'h8000_000C, 0, 0, 1, 1, 0, S1D, 0, 1));
        tbl.push_back(v(0, 0, 7, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 7, 32'h9000_0000, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 7, 32'h9000_0000, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 7, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 7, 32'h100, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 7, 32'h100, 0, 0, 1, 0, 0, DB, 1, 0));
        tbl.push_back(v(1, 1, 7, 32'h100, 1, 0, 1, 1, 0, DB, 1, 0));
        tbl.push_back(v(0, 0, 7, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 7, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 7, 32'h200, 0, 1, 0, 1, 1, DB, 1, 0));
        tbl.push_back(v(0, 0, 7, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 2, 32'h8000_0010, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 2, 32'h8000_0010, 0, 0, 0, 0, 0, S1D, 0, 1));
        tbl.push_back(v(0, 0, 2, 32'h8000_0010, 0, 0, 0, 0, 0, S1D, 0, 0));
        tbl.push_back(v(1, 1, 7, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 7, 32'h20, 1, 0, 0, 1, 0, DB, 1, 0));
        tbl.push_back(v(0, 0, 7, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(tbl[i].cyc, tbl[i].stb, tbl[i].cti, tbl[i].adr);
            resp(tbl[i].a0, tbl[i].e0, tbl[i].a1, 1'b0);
            @(negedge clk);
            check({nm, ".ack"}, 32'(wb.ack), 32'(tbl[i].eack));
            check({nm, ".err"}, 32'(wb.err), 32'(tbl[i].eerr));
            check({nm, ".dat"}, wb.rdat, tbl[i].edat);
            check({nm, ".s0stb"}, 32'(s0.stb), 32'(tbl[i].es0));
            check({nm, ".s0cyc"}, 32'(s0.cyc), 32'(tbl[i].es0));
            check({nm, ".s1stb"}, 32'(s1.stb), 32'(tbl[i].es1));
            check({nm, ".s1cyc"}, 32'(s1.cyc), 32'(tbl[i].es1));
            tick();
        end

        // Reset landing on the second beat of an S0 burst.
        drive(1, 1, 3'b010, 32'h40);
        resp(1, 0, 0, 0);
        @(negedge clk);
        check("rst.idle_ack", 32'(wb.ack), 0);
        tick();
        @(negedge clk);
        check("rst.beat1_ack", 32'(wb.ack), 1);
        check("rst.beat1_stb", 32'(s0.stb), 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst.beat2_ack", 32'(wb.ack), 1);
        tick();
        @(negedge clk);
        check_idle_bus("rst.after");
        tick();
        rst = 1'b0;
        drive(1, 1, 3'b111, 32'h40);
        @(negedge clk);
        check("rst.redecode_stb", 32'(s0.stb), 0);
        check("rst.redecode_ack", 32'(wb.ack), 0);
        tick();
        @(negedge clk);
        check("rst.again_stb", 32'(s0.stb), 1);
        check("rst.again_ack", 32'(wb.ack), 1);
        tick();
        drive(0, 0, 3'b111, 0);
        resp(0, 0, 0, 0);
        tick();

`ifdef ZAP_WB_SPLIT_TIMEOUT_EN
        for (int sc = 0; sc < 3; sc++) begin
            string nm;
            nm = $sformatf("tmo%0d", sc);
            drive(1, 1, (sc == 2) ? 3'b010 : 3'b111, 32'h50);
            resp(0, 0, 0, 0);
            @(negedge clk);
            check({nm, ".idle_stb"}, 32'(s0.stb), 0);
            tick();
            for (int k = 0; k < TO; k++) begin
                @(negedge clk);
                check($sformatf("%s.wait%0d_ack", nm, k), 32'(wb.ack), 0);
                check($sformatf("%s.wait%0d_stb", nm, k), 32'(s0.stb), 1);
                tick();
            end
            if (sc == 1) s0.ack = 1'b1;
            @(negedge clk);
            check({nm, ".ack"}, 32'(wb.ack), 1);
            check({nm, ".err"}, 32'(wb.err), (sc == 1) ? 0 : 1);
            check({nm, ".stb"}, 32'(s0.stb), (sc == 1) ? 1 : 0);
            check({nm, ".cyc"}, 32'(s0.cyc), (sc == 1) ? 1 : 0);
            tick();
            resp(0, 0, 0, 0);
            if (sc == 2) begin
                @(negedge clk);
                check({nm, ".err_beat_ack"}, 32'(wb.ack), 1);
                check({nm, ".err_beat_err"}, 32'(wb.err), 1);
                check({nm, ".err_beat_stb"}, 32'(s0.stb), 0);
                tick();
            end
            drive(0, 0, 3'b111, 0);
            @(negedge clk);
            check({nm, ".done_stb"}, 32'(s0.stb), 0);
            tick();
        end
`endif

        // Randomized traffic against the reference model.
        rst = 1'b1;
        tick();
        model_step();
        tick();
        rst = 1'b0;
        m_sel  = -1;
        m_wait = 0;
        for (int n = 0; n < 1500; n++) begin
            wb.cyc  = ($urandom_range(0, 9) < 8);
            wb.stb  = wb.cyc && ($urandom_range(0, 9) < 8);
            wb.wen  = 1'($urandom);
            wb.sel  = 4'($urandom);
            wb.dat  = $urandom;
            wb.adr  = rnd_adr();
            wb.cti  = ($urandom_range(0, 9) < 4) ? 3'b111 : 3'b010;
            s0.ack  = ($urandom_range(0, 9) < 5);
            s0.err  = ($urandom_range(0, 19) == 0);
            s1.ack  = ($urandom_range(0, 9) < 5);
            s1.err  = ($urandom_range(0, 19) == 0);
            s0.rdat = $urandom;
            s1.rdat = $urandom;
            rst     = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            predict();
            check("rnd.ack", 32'(wb.ack), 32'(e_ack));
            check("rnd.err", 32'(wb.err), 32'(e_err));
            check("rnd.dat", wb.rdat, e_dat);
            cmp_rsp("rnd.s0", 0, s0.cyc, s0.stb, s0.wen, s0.sel,
                    s0.dat, s0.adr, s0.cti);
            cmp_rsp("rnd.s1", 1, s1.cyc, s1.stb, s1.wen, s1.sel,
                    s1.dat, s1.adr, s1.cti);
            @(posedge clk);
            model_step();
            #1;
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule

// File: doc/zap_wb_splitter.md
# zap_wb_splitter

Routes one Wishbone initiator onto two Wishbone responders (S0, S1) by address decode, and terminates unmapped accesses internally with a bus error. It sits downstream of the shared I/D bus and fans that single bus out to, e.g., memory controller (S0) and peripheral fabric (S1). Target selection is latched for the whole cycle, so bursts are never split across responders.

## Interface
- S0_BASE, 32'h0000_0000, S0 match value.
- S0_MASK, 32'h8000_0000, S0 decode mask; hit when (adr & S0_MASK) == S0_BASE.
- S1_BASE, 32'h8000_0000, S1 match value.
- S1_MASK, 32'hF000_0000, S1 decode mask.
- TIMEOUT, 255, max wait cycles per beat (used only with timeout feature), range 1..65535.
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_wb_cyc, i_wb_stb, i_wb_wen  in  1 each  initiator cycle, strobe, write enable.
- i_wb_sel  in  4  byte selects.
- i_wb_dat  in  32  write data.
- i_wb_adr  in  32  byte address.
- i_wb_cti  in  3  cycle type; 3'b111 = EOB.
- o_wb_ack  out  1  beat done (also asserted with err).
- o_wb_err  out  1  beat error.
- o_wb_dat  out  32  read data from selected responder.
- o_sN_wb_cyc, o_sN_wb_stb, o_sN_wb_wen  out  1 each  (N = 0,1) responder controls.
- o_sN_wb_sel  out  4; o_sN_wb_dat  out  32; o_sN_wb_adr  out  32; o_sN_wb_cti  out  3.
- i_sN_wb_dat  in  32; i_sN_wb_ack  in  1; i_sN_wb_err  in  1.

## Operation
- FSM states: IDLE, S0, S1, ERR (state register flopped; all outputs combinational from state and inputs).
- IDLE: no responder driven. If i_wb_cyc & i_wb_stb: decode i_wb_adr; S0 hit -> S0 (S0 wins if both hit); else S1 hit -> S1; else ERR. No ack issued in IDLE.
- S0/S1: selected responder gets cyc/stb/wen/sel/dat/adr/cti passed through from initiator; unselected responder gets cyc=0, stb=0, wen=0, sel=0, dat=0, adr=0, cti=3'b111. o_wb_ack = i_sN_ack | i_sN_err; o_wb_err = i_sN_err; o_wb_dat = i_sN_dat.
- ERR: each cycle with i_wb_stb asserts o_wb_ack=1, o_wb_err=1, o_wb_dat=0.
- Exit to IDLE from S0/S1/ERR when (o_wb_ack & i_wb_cti==3'b111) or !i_wb_cyc. Otherwise selection holds, including across address changes within a burst.
- Acks/errs from the unselected responder are ignored. o_wb_dat = 0 when nothing selected.

## Timing
- Reset: state IDLE; all o_sN_* zero except o_sN_wb_cti=3'b111; o_wb_ack=0, o_wb_err=0, o_wb_dat=0.
- Decode latency: initiator stb first seen in cycle N (IDLE) -> responder stb in cycle N+1. Subsequent burst beats pass with zero added latency.
- Ack path is combinational: responder ack in cycle M -> o_wb_ack in cycle M.
- Back-to-back: EOB ack at cycle M -> IDLE at M+1; new request decoded at M+1, responder stb at M+2.
- Initiator drops cyc mid-burst: responder cyc/stb drop same cycle (pass-through); state IDLE next cycle.
- Reset asserted mid-burst: state IDLE after the reset edge; responder outputs drop then; no ack generated.

## Configuration
- ZAP_WB_SPLIT_TIMEOUT_EN defined: a wait counter (width clog2(TIMEOUT+1)) clears on entry to S0/S1 and on every o_wb_ack, increments each S0/S1 cycle with stb and no responder ack. When it reaches TIMEOUT with no responder ack that cycle, block asserts o_wb_ack=1, o_wb_err=1, forces responder stb and cyc low that cycle, and moves to IDLE if cti==EOB, else to ERR (remaining beats error). Responder ack in the same cycle wins; no timeout.
- Not defined: no counter, no forced termination; a silent responder stalls the bus indefinitely.

## Test plan
- Single read 0x0000_0010, S0 acks 2 cycles after its stb with dat 0xDEAD_BEEF -> o_s0_wb_stb 1 cycle after i_wb_stb, o_wb_dat=0xDEAD_BEEF with ack, S1 never driven.
- 4-beat incrementing burst at 0x8000_0000 (cti 010,010,010,111) with S1 acking every cycle -> 4 acks in 4 consecutive cycles, then IDLE.
- Access to 0x9000_0000 (no hit) -> o_wb_ack=1 & o_wb_err=1 one cycle after stb, both responders idle.
- Spurious i_s1_wb_ack while S0 active -> o_wb_ack follows only S0.
- i_reset during S0 burst beat 2 -> after the edge all responder controls 0, o_sN_wb_cti=3'b111, no ack; next request re-decodes.
- With ZAP_WB_SPLIT_TIMEOUT_EN, TIMEOUT=8, S0 silent -> err+ack exactly 8 cycles after o_s0_wb_stb first asserted; S0 ack in that same cycle -> normal ack, no err.
